// File: rtl/cpu_ctrl_fsm.sv
// Machine-cycle controller for the 8-bit accumulator CPU: 8-phase fetch/execute
// sequencer with memory wait handshake and a bus-timeout watchdog.
module cpu_ctrl_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int WCNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S0     = 4'd1,
    S1     = 4'd2,
    S2     = 4'd3,
    S3     = 4'd4,
    S4     = 4'd5,
    S5     = 4'd6,
    S6     = 4'd7,
    S7     = 4'd8,
    HALTED = 4'd9
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              alu_op, stall, wd_fire;

  assign alu_op  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
  assign wd_fire = (WAIT_MAX != 0) && (wcnt_q == WAIT_LIM);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    state_d     = state_q;

    case (state_q)
      IDLE: if (ena) state_d = S0;
      S0: begin
        rd      = 1'b1;
        load_ir = mem_ready;
        state_d = S1;
      end
      S1: begin
        rd      = 1'b1;
        load_ir = mem_ready;
        inc_pc  = mem_ready;
        state_d = S2;
      end
      S2: state_d = S3;
      S3: begin
        if (opcode == OP_HLT) begin
          halt    = 1'b1;
          state_d = HALTED;
        end else begin
          inc_pc  = 1'b1;
          state_d = S4;
        end
      end
      S4: begin
        if (alu_op)                rd          = 1'b1;
        else if (opcode == OP_STO) datactl_ena = 1'b1;
        else if (opcode == OP_JMP) load_pc     = 1'b1;
        state_d = S5;
      end
      S5: begin
        if (alu_op) begin
          rd       = 1'b1;
          load_acc = mem_ready;
        end else if (opcode == OP_SKZ) begin
          inc_pc = zero;
        end else if (opcode == OP_JMP) begin
          load_pc = 1'b1;
          inc_pc  = 1'b1;
        end else if (opcode == OP_STO) begin
          wr          = 1'b1;
          datactl_ena = 1'b1;
        end
        state_d = S6;
      end
      S6: begin
        if (alu_op)                rd          = 1'b1;
        else if (opcode == OP_STO) datactl_ena = 1'b1;
        state_d = S7;
      end
      S7: begin
        if (opcode == OP_SKZ) inc_pc = zero;
        state_d = S0;
      end
      HALTED: halt = 1'b1;
      default: state_d = IDLE;
    endcase

    // An access that is still waiting overrides the advance decided above.
    if (stall) state_d = wd_fire ? HALTED : state_q;
  end

  assign stall = (rd || wr) && !mem_ready;

  always_comb begin
    wcnt_d = '0;
    if (stall && !wd_fire)
      wcnt_d = (wcnt_q == WAIT_LIM) ? wcnt_q : wcnt_q + 1'b1;
    err_d = err_q || (stall && wd_fire);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus_err = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed per-cycle vectors push expected
// {state, strobes}; a negedge monitor pops and compares.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, bus_err;
  logic [3:0] state;

  cpu_ctrl_fsm #(.WAIT_MAX(15), .WCNT_W(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .rd(rd), .wr(wr), .load_ir(load_ir),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .datactl_ena(datactl_ena), .halt(halt), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] RD   = 9'h100;
  localparam logic [8:0] WR   = 9'h080;
  localparam logic [8:0] LIR  = 9'h040;
  localparam logic [8:0] IPC  = 9'h020;
  localparam logic [8:0] LPC  = 9'h010;
  localparam logic [8:0] LACC = 9'h008;
  localparam logic [8:0] DCTL = 9'h004;
  localparam logic [8:0] HLTF = 9'h002;
  localparam logic [8:0] BERR = 9'h001;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // Monitor: compares whatever expectation was queued for this cycle.
  always @(negedge clk) begin
    logic [12:0] act, e;
    string       n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {state, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, bus_err};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s @%0t: got state=%0d flags=%b, expected state=%0d flags=%b",
                 n, $time, act[12:9], act[8:0], e[12:9], e[8:0]);
      end
    end
  end

  task automatic push(input logic [3:0] st, input logic [8:0] fl, input string n);
    exp_q.push_back({st, fl});
    name_q.push_back(n);
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z,
                      input logic mr, input logic [3:0] st, input logic [8:0] fl,
                      input string n);
    @(posedge clk);
    #1;
    reset = r; ena = e; opcode = op; zero = z; mem_ready = mr;
    push(st, fl, n);
  endtask

  // One instruction with no stalls; S0..S3 are common to every non-HLT opcode.
  task automatic run_instr(input logic [2:0] op, input logic z, input logic [8:0] f4,
                           input logic [8:0] f5, input logic [8:0] f6,
                           input logic [8:0] f7, input string n);
    step(1, 1, op, z, 1, 4'd1, RD | LIR, {n, "_s0"});
    step(1, 0, op, z, 1, 4'd2, RD | LIR | IPC, {n, "_s1"});
    step(1, 1, op, z, 1, 4'd3, NONE, {n, "_s2"});
    step(1, 0, op, z, 1, 4'd4, IPC, {n, "_s3"});
    step(1, 1, op, z, 1, 4'd5, f4, {n, "_s4"});
    step(1, 0, op, z, 1, 4'd6, f5, {n, "_s5"});
    step(1, 1, op, z, 1, 4'd7, f6, {n, "_s6"});
    step(1, 0, op, z, 1, 4'd8, f7, {n, "_s7"});
  endtask

  initial begin
    // Reset held, then idle with ena low, then start.
    step(0, 1, LDA, 0, 1, 4'd0, NONE, "reset0");
    step(0, 1, LDA, 0, 1, 4'd0, NONE, "reset1");
    step(1, 0, LDA, 0, 1, 4'd0, NONE, "idle_hold");
    step(1, 1, LDA, 0, 1, 4'd0, NONE, "idle_go");

    run_instr(LDA, 0, RD, RD | LACC, RD, NONE, "lda_a");
    run_instr(LDA, 1, RD, RD | LACC, RD, NONE, "lda_b");
    run_instr(ADD, 0, RD, RD | LACC, RD, NONE, "add");
    run_instr(AND_, 1, RD, RD | LACC, RD, NONE, "and");
    run_instr(XOR_, 0, RD, RD | LACC, RD, NONE, "xor");
    run_instr(SKZ, 1, NONE, IPC, NONE, IPC, "skz_z1");
    run_instr(SKZ, 0, NONE, NONE, NONE, NONE, "skz_z0");
    run_instr(JMP, 0, LPC, LPC | IPC, NONE, NONE, "jmp");
    run_instr(STO, 0, DCTL, WR | DCTL, DCTL, NONE, "sto");

    // STO with a 3-cycle stall at S5 and ena dropped mid-instruction.
    step(1, 0, STO, 0, 1, 4'd1, RD | LIR, "stos_s0");
    step(1, 0, STO, 0, 1, 4'd2, RD | LIR | IPC, "stos_s1");
    step(1, 0, STO, 0, 1, 4'd3, NONE, "stos_s2");
    step(1, 0, STO, 0, 1, 4'd4, IPC, "stos_s3");
    step(1, 0, STO, 0, 1, 4'd5, DCTL, "stos_s4");
    step(1, 0, STO, 0, 0, 4'd6, WR | DCTL, "stos_wait1");
    step(1, 0, STO, 0, 0, 4'd6, WR | DCTL, "stos_wait2");
    step(1, 0, STO, 0, 0, 4'd6, WR | DCTL, "stos_wait3");
    step(1, 0, STO, 0, 1, 4'd6, WR | DCTL, "stos_done");
    step(1, 0, STO, 0, 1, 4'd7, DCTL, "stos_s6");
    step(1, 0, STO, 0, 1, 4'd8, NONE, "stos_s7");

    // HLT: halt at S3, then HALTED for 20 cycles regardless of ena/mem_ready.
    step(1, 1, HLT, 0, 1, 4'd1, RD | LIR, "hlt_s0");
    step(1, 1, HLT, 0, 1, 4'd2, RD | LIR | IPC, "hlt_s1");
    step(1, 1, HLT, 0, 1, 4'd3, NONE, "hlt_s2");
    step(1, 1, HLT, 0, 1, 4'd4, HLTF, "hlt_s3");
    for (int i = 0; i < 20; i++)
      step(1, logic'(i[0]), HLT, logic'(i[1]), logic'(i[2]), 4'd9, HLTF, "halted_hold");
    step(0, 1, HLT, 0, 1, 4'd0, NONE, "hlt_reset");

    // Watchdog fires after exactly 16 stall cycles at S0.
    step(1, 1, LDA, 0, 0, 4'd0, NONE, "wd_idle");
    for (int i = 0; i < 16; i++)
      step(1, 1, LDA, 0, 0, 4'd1, RD, "wd_stall");
    step(1, 1, LDA, 0, 0, 4'd9, HLTF | BERR, "wd_fired");
    step(1, 0, LDA, 0, 1, 4'd9, HLTF | BERR, "wd_sticky");
    step(0, 1, LDA, 0, 1, 4'd0, NONE, "wd_reset");

    // mem_ready arrives on the 16th cycle: access completes, no error.
    step(1, 1, LDA, 0, 0, 4'd0, NONE, "wd2_idle");
    for (int i = 0; i < 15; i++)
      step(1, 1, LDA, 0, 0, 4'd1, RD, "wd2_stall");
    step(1, 1, LDA, 0, 1, 4'd1, RD | LIR, "wd2_ready_at_limit");
    step(1, 1, LDA, 0, 1, 4'd2, RD | LIR | IPC, "wd2_s1");
    step(1, 1, LDA, 0, 1, 4'd3, NONE, "wd2_s2");
    step(1, 1, LDA, 0, 1, 4'd4, IPC, "wd2_s3");
    step(1, 1, LDA, 0, 0, 4'd5, RD, "wd2_s4_stall");
    step(1, 1, LDA, 0, 0, 4'd5, RD, "wd2_s4_stall2");

    // Asynchronous reset between edges, mid-stall.
    @(posedge clk);
    #2;
    reset = 1'b0;
    push(4'd0, NONE, "async_reset");
    step(0, 1, LDA, 0, 0, 4'd0, NONE, "async_reset_hold");
    step(1, 0, LDA, 0, 1, 4'd0, NONE, "post_reset_idle");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Machine-cycle controller for the 8-bit-data / 13-bit-address accumulator CPU.
- Sequences the instruction register, PC, accumulator, ALU output driver and memory strobes through an 8-phase fetch/execute cycle.
- Adds a memory wait handshake and a bus-timeout watchdog.
- Sits inside `cpu`, between the instruction register/accumulator zero flag and the datapath enables.

Parameters:
- WAIT_MAX, 15: max consecutive cycles a memory access may stall on mem_ready=0 before bus error; 0 disables the watchdog.
- WCNT_W, 4: width of the wait counter; must satisfy 2^WCNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ena  in  1  run enable; sampled only in IDLE.
- opcode  in  3  IR opcode: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- zero  in  1  accumulator == 0.
- mem_ready  in  1  memory completes the current rd/wr access this cycle.
- rd  out  1  memory read strobe.
- wr  out  1  memory write strobe.
- load_ir  out  1  load IR byte from data bus.
- inc_pc  out  1  PC += 1.
- load_pc  out  1  PC <= ir_addr.
- load_acc  out  1  ACC <= ALU result.
- datactl_ena  out  1  drive ACC onto data bus.
- halt  out  1  CPU halted, sticky.
- bus_err  out  1  watchdog fired, sticky.
- state  out  4  current state code, debug only.

Behaviour:
- State codes: IDLE=0, S0..S7=1..8, HALTED=9.
- Reset (reset=0, async) puts the block in IDLE with the wait counter at 0.
- All outputs are 0 during and after reset.
- Outputs are a combinational decode of (state, opcode, zero, mem_ready); only the state register and wait counter are registered.
- IDLE: when ena=1, go to S0 next cycle; otherwise hold.
- Access states are states in which rd or wr is asserted.
  - In an access state the state holds while mem_ready=0.
  - Single-cycle strobes (load_ir, inc_pc, load_pc, load_acc) assert only in the cycle where mem_ready=1, so each fires exactly once per state visit.
  - rd, wr and datactl_ena stay asserted for the whole stall.
- Non-access states advance unconditionally after 1 cycle.
- Per-state decode:
  - S0: rd; load_ir when ready (IR high byte).
  - S1: rd; load_ir and inc_pc when ready (IR low byte).
  - S2: no outputs.
  - S3: HLT → halt=1, next state HALTED. Any other opcode → inc_pc=1, next S4.
  - S4:
    - ADD/AND/XOR/LDA: rd.
    - STO: datactl_ena.
    - JMP: load_pc.
    - HLT/SKZ: none.
  - S5:
    - ADD/AND/XOR/LDA: rd; load_acc when ready.
    - SKZ with zero=1: inc_pc.
    - JMP: load_pc and inc_pc.
    - STO: wr and datactl_ena.
  - S6:
    - ADD/AND/XOR/LDA: rd.
    - STO: datactl_ena.
  - S7: SKZ with zero=1 → inc_pc. Next S0.
- A fetch-execute cycle is 8 cycles with zero stalls, plus 1 cycle per stalled access cycle.
- ena is not checked after IDLE; deasserting ena mid-instruction has no effect.
- HALTED: halt=1, all other strobes 0, hold until reset.
- Watchdog (only when WAIT_MAX≠0):
  - The wait counter increments each cycle in an access state with mem_ready=0, and clears when mem_ready=1 or on any state change.
  - When the counter reaches WAIT_MAX with mem_ready still 0, the next state is HALTED with bus_err=1 and halt=1. rd and wr drop in that next cycle.
  - mem_ready=1 in the same cycle the counter hits WAIT_MAX: the access completes normally and no error is raised.
  - The counter saturates and never wraps.
- zero is sampled combinationally in S5/S7 and must be stable in those cycles.
- Opcode is treated as stable from S2 onward; no latching inside the block.
- reset low mid-stall or mid-write drops wr/rd immediately (async) and returns the block to IDLE.

Test Plan:
- Reset, then ena=1, opcode=LDA, mem_ready=1 always:
  - States 1..8 repeating.
  - rd high in S0,S1,S4,S5,S6; load_acc exactly once at S5.
  - inc_pc exactly 2 times per instruction (S1, S3).
  - 8 cycles/instruction.
- opcode=SKZ:
  - zero=1: inc_pc pulses at S1, S3, S5, S7 (4 total).
  - zero=0: 2 pulses.
- opcode=STO with mem_ready=0 for 3 cycles at S5:
  - wr and datactl_ena held 4 cycles.
  - No extra inc_pc.
  - Instruction takes 11 cycles.
- opcode=JMP: load_pc in S4 and S5, inc_pc in S1, S3, S5; no rd in S4–S6.
- opcode=HLT:
  - halt=1 at S3, then state=9 held for 20 cycles with all strobes 0.
  - Toggling ena has no effect; reset returns state=0.
- WAIT_MAX=15, mem_ready stuck 0 at S0:
  - bus_err=1, halt=1 and rd=0 after exactly 16 stall cycles.
  - Repeat with mem_ready=1 on the 16th cycle → no bus_err.
  - Assert reset mid-stall → all outputs 0 asynchronously.
